// File: rtl/matrix_pkg.sv
// Shared definitions for the LED matrix scan controller: state encoding and
// default panel geometry / display-hold timing.
package matrix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_BLANK,
        ST_LATCH,
        ST_DISPLAY
    } scan_state_e;

    localparam int DEF_COLS        = 64;
    localparam int DEF_ROWS        = 16;
    localparam int DEF_DISP_CYCLES = 64;

endpackage

// File: rtl/led_matrix_scan.sv
// HUB75-style scan controller: shifts one line of pixels into the panel, blanks,
// latches it, then holds it lit for DISP_CYCLES before moving to the next line.
module led_matrix_scan
    import matrix_pkg::*;
#(
    parameter int COLS        = DEF_COLS,
    parameter int ROWS        = DEF_ROWS,
    parameter int DISP_CYCLES = DEF_DISP_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [5:0] col,
    output logic [3:0] row,
    input  logic       r0_in,
    input  logic       g0_in,
    input  logic       b0_in,
    input  logic       r1_in,
    input  logic       g1_in,
    input  logic       b1_in,
    output logic       r0,
    output logic       g0,
    output logic       b0,
    output logic       r1,
    output logic       g1,
    output logic       b1,
    output logic       panel_clk,
    output logic       lat,
    output logic       oe_n,
    output logic [3:0] addr,
    output logic       frame_start
);

    localparam logic [5:0] LAST_COL  = 6'(COLS - 1);
    localparam logic [3:0] LAST_ROW  = 4'(ROWS - 1);
    localparam logic [7:0] HOLD_INIT = 8'(DISP_CYCLES - 1);

    scan_state_e state_q, state_d;
    logic        phase_q, phase_d;
    logic [5:0]  col_q, col_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  addr_q, addr_d;
    logic [7:0]  hold_q, hold_d;
    logic        latched_q, latched_d;
    logic [5:0]  pix_q, pix_d;
    logic        panel_clk_q, panel_clk_d;
    logic        lat_q, lat_d;
    logic        oe_n_q, oe_n_d;
    logic        frame_start_q, frame_start_d;
    logic        advance;
    logic        shift_a;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        col_d     = col_q;
        row_d     = row_q;
        addr_d    = addr_q;
        hold_d    = hold_q;
        latched_d = latched_q;
        advance   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                latched_d = 1'b0;
                col_d     = '0;
                row_d     = '0;
                phase_d   = 1'b0;
                if (enable) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (col_q == LAST_COL) begin
                        col_d   = '0;
                        state_d = ST_BLANK;
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end
            end
            ST_BLANK: state_d = ST_LATCH;
            ST_LATCH: begin
                addr_d    = row_q;
                latched_d = 1'b1;
                if (DISP_CYCLES == 0) begin
                    advance = 1'b1;
                end else begin
                    hold_d  = HOLD_INIT;
                    state_d = ST_DISPLAY;
                end
            end
            ST_DISPLAY: begin
                if (hold_q == 8'd0) advance = 1'b1;
                else                hold_d  = hold_q - 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        // enable is only honoured here, so a line in flight always finishes
        if (advance) begin
            phase_d = 1'b0;
            col_d   = '0;
            row_d   = (row_q == LAST_ROW || !enable) ? 4'd0 : row_q + 4'd1;
            state_d = enable ? ST_SHIFT : ST_IDLE;
            if (!enable) latched_d = 1'b0;
        end

        // Panel pins are registered from the current state, trailing col/row by
        // one cycle: data settles a full cycle before each panel_clk rise.
        shift_a       = (state_q == ST_SHIFT) && !phase_q;
        panel_clk_d   = (state_q == ST_SHIFT) && phase_q;
        lat_d         = (state_q == ST_LATCH);
        oe_n_d        = !((state_q == ST_DISPLAY) || ((state_q == ST_SHIFT) && latched_q));
        frame_start_d = shift_a && (col_q == 6'd0) && (row_q == 4'd0);
        pix_d         = shift_a ? {r0_in, g0_in, b0_in, r1_in, g1_in, b1_in} : pix_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            phase_q       <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
            addr_q        <= '0;
            hold_q        <= '0;
            latched_q     <= 1'b0;
            pix_q         <= '0;
            panel_clk_q   <= 1'b0;
            lat_q         <= 1'b0;
            oe_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            col_q         <= col_d;
            row_q         <= row_d;
            addr_q        <= addr_d;
            hold_q        <= hold_d;
            latched_q     <= latched_d;
            pix_q         <= pix_d;
            panel_clk_q   <= panel_clk_d;
            lat_q         <= lat_d;
            oe_n_q        <= oe_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign col         = col_q;
    assign row         = row_q;
    assign addr        = addr_q;
    assign {r0, g0, b0, r1, g1, b1} = pix_q;
    assign panel_clk   = panel_clk_q;
    assign lat         = lat_q;
    assign oe_n        = oe_n_q;
    assign frame_start = frame_start_q;

endmodule
